// File: rtl/pwm_servo_bus_master_pkg.sv
// Shared definitions for the servo PWM bus master: register offsets within
// a channel block, channel stride, FSM states, bus access type codes and the
// channel base address helper.
package pwm_servo_bus_master_pkg;

  localparam logic [7:0] E_OFS     = 8'd0;
  localparam logic [7:0] T_OFS     = 8'd4;
  localparam logic [7:0] D_OFS     = 8'd8;
  localparam logic [7:0] CH_STRIDE = 8'd12;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_DIS, ST_WR_T, ST_WR_D, ST_WR_EN, ST_RD_T, ST_RD_D, ST_DONE
  } state_e;

  typedef enum logic {
    ACC_WR = 1'b0,
    ACC_RD = 1'b1
  } acc_kind_e;

  // ch*12 built from two shifts, added to the block base with 8-bit wrap.
  function automatic logic [7:0] ch_base(input logic [7:0] base, input logic [2:0] ch);
    return base + {2'b00, ch, 3'b000} + {3'b000, ch, 2'b00};
  endfunction

endpackage

// File: rtl/pwm_servo_bus_master_if.sv
// Command + peripheral bus bundle for pwm_servo_bus_master.
//  master: the bus master side (accepts commands, drives cs/wr/rd/addr/d_out)
//  slave : the command source / peripheral side
interface pwm_servo_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_ch;
  logic        cmd_en;
  logic [31:0] cmd_period;
  logic [31:0] cmd_duty;
  logic        done;
  logic        err;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [7:0]  addr;
  logic [31:0] d_out;
  logic [31:0] d_in;

  modport master (
    input  cmd_valid, cmd_ch, cmd_en, cmd_period, cmd_duty, d_in,
    output cmd_ready, done, err, cs, wr, rd, addr, d_out
  );

  modport slave (
    output cmd_valid, cmd_ch, cmd_en, cmd_period, cmd_duty, d_in,
    input  cmd_ready, done, err, cs, wr, rd, addr, d_out
  );
endinterface

// File: rtl/pwm_servo_bus_master_access.sv
// pwm_bus_access: single bus access engine.
//  start_i  : launch an access this edge (only while idle or when ack_o is high)
//  kind_i   : ACC_WR / ACC_RD
//  addr_i, wdata_i : access address / write data
//  d_in_i   : peripheral read data, captured at the edge ending the rd cycle
//  cs_o/wr_o/rd_o/addr_o/d_out_o : registered bus, high for exactly one cycle
//  rdata_o  : last captured read data
//  ack_o    : high in the last gap cycle, so the next access can start
//             back-to-back with no extra idle cycle
module pwm_bus_access
  import pwm_servo_bus_master_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  acc_kind_e   kind_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] d_in_i,
  output logic        cs_o,
  output logic        wr_o,
  output logic        rd_o,
  output logic [7:0]  addr_o,
  output logic [31:0] d_out_o,
  output logic [31:0] rdata_o,
  output logic        ack_o
);

  localparam logic [1:0] GAP_W = 2'(GAP_CYCLES);

  logic        cs_q, wr_q, rd_q;
  logic [7:0]  addr_q;
  logic [31:0] dout_q, rdata_q;
  logic [1:0]  gap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q    <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= 8'h00;
      dout_q  <= 32'h0;
      rdata_q <= 32'h0;
      gap_q   <= 2'd0;
    end else if (start_i) begin
      cs_q   <= 1'b1;
      wr_q   <= (kind_i == ACC_WR);
      rd_q   <= (kind_i == ACC_RD);
      addr_q <= addr_i;
      dout_q <= (kind_i == ACC_WR) ? wdata_i : 32'h0;
      gap_q  <= 2'd0;
    end else if (cs_q) begin
      // Drive cycle ends: drop the bus and start counting idle cycles.
      cs_q   <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 8'h00;
      dout_q <= 32'h0;
      gap_q  <= GAP_W;
      if (rd_q) rdata_q <= d_in_i;
    end else if (gap_q != 2'd0) begin
      gap_q <= gap_q - 2'd1;
    end
  end

  assign cs_o    = cs_q;
  assign wr_o    = wr_q;
  assign rd_o    = rd_q;
  assign addr_o  = addr_q;
  assign d_out_o = dout_q;
  assign rdata_o = rdata_q;
  assign ack_o   = (gap_q == 2'd1);

endmodule

// File: rtl/pwm_servo_bus_master.sv
// pwm_servo_bus_master: turns one servo command into the register write
// sequence E=0, T, D, E=en on the 8-channel PWM peripheral.
//  clk, rst_n : clock, async active-low reset
//  bus        : pwm_servo_bus_master_if.master (command handshake, done/err,
//               cs/wr/rd/addr/d_out/d_in peripheral bus)
// Optional feature macro PWM_READBACK_VERIFY_EN: reads T and D back after
// the final enable write and sets sticky err on mismatch. Without it rd is
// never raised and err stays 0.
module pwm_servo_bus_master
  import pwm_servo_bus_master_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'h00,
  parameter int         GAP_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  pwm_servo_bus_master_if.master bus
);

  state_e      state_q, state_d;
  logic [7:0]  chb_q;
  logic        en_q;
  logic [31:0] period_q, duty_q;

  logic        acc_start, acc_ack;
  acc_kind_e   acc_kind;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wdata, acc_rdata;
  logic        accept, cmd_ready, done;

  pwm_bus_access #(.GAP_CYCLES(GAP_CYCLES)) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(acc_start),
    .kind_i (acc_kind),
    .addr_i (acc_addr),
    .wdata_i(acc_wdata),
    .d_in_i (bus.d_in),
    .cs_o   (bus.cs),
    .wr_o   (bus.wr),
    .rd_o   (bus.rd),
    .addr_o (bus.addr),
    .d_out_o(bus.d_out),
    .rdata_o(acc_rdata),
    .ack_o  (acc_ack)
  );

`ifdef PWM_READBACK_VERIFY_EN
  logic chk_t, chk_d;
`endif

  // Each access state covers its drive cycle plus gap; the next access is
  // launched on the ack cycle so accesses run back-to-back.
  always_comb begin
    state_d   = state_q;
    acc_start = 1'b0;
    acc_kind  = ACC_WR;
    acc_addr  = 8'h00;
    acc_wdata = 32'h0;
    cmd_ready = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
`ifdef PWM_READBACK_VERIFY_EN
    chk_t     = 1'b0;
    chk_d     = 1'b0;
`endif
    case (state_q)
      // DONE behaves like IDLE for acceptance so a new command can start in
      // the same cycle the done pulse is shown.
      ST_IDLE, ST_DONE: begin
        cmd_ready = 1'b1;
        done      = (state_q == ST_DONE);
        state_d   = ST_IDLE;
        if (bus.cmd_valid) begin
          accept    = 1'b1;
          acc_start = 1'b1;
          acc_addr  = ch_base(BASE_ADDR, bus.cmd_ch) + E_OFS;
          state_d   = ST_WR_DIS;
        end
      end
      ST_WR_DIS: if (acc_ack) begin
        acc_start = 1'b1;
        acc_addr  = chb_q + T_OFS;
        acc_wdata = period_q;
        state_d   = ST_WR_T;
      end
      ST_WR_T: if (acc_ack) begin
        acc_start = 1'b1;
        acc_addr  = chb_q + D_OFS;
        acc_wdata = duty_q;
        state_d   = ST_WR_D;
      end
      ST_WR_D: if (acc_ack) begin
        acc_start = 1'b1;
        acc_addr  = chb_q + E_OFS;
        acc_wdata = {31'b0, en_q};
        state_d   = ST_WR_EN;
      end
      ST_WR_EN: if (acc_ack) begin
`ifdef PWM_READBACK_VERIFY_EN
        acc_start = 1'b1;
        acc_kind  = ACC_RD;
        acc_addr  = chb_q + T_OFS;
        state_d   = ST_RD_T;
`else
        state_d   = ST_DONE;
`endif
      end
`ifdef PWM_READBACK_VERIFY_EN
      ST_RD_T: if (acc_ack) begin
        chk_t     = 1'b1;
        acc_start = 1'b1;
        acc_kind  = ACC_RD;
        acc_addr  = chb_q + D_OFS;
        state_d   = ST_RD_D;
      end
      ST_RD_D: if (acc_ack) begin
        chk_d   = 1'b1;
        state_d = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      chb_q    <= 8'h00;
      en_q     <= 1'b0;
      period_q <= 32'h0;
      duty_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        chb_q    <= ch_base(BASE_ADDR, bus.cmd_ch);
        en_q     <= bus.cmd_en & (bus.cmd_period != 32'h0);
        period_q <= bus.cmd_period;
        duty_q   <= (bus.cmd_duty > bus.cmd_period) ? bus.cmd_period : bus.cmd_duty;
      end
    end
  end

`ifdef PWM_READBACK_VERIFY_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (accept)
      err_q <= 1'b0;
    else if ((chk_t && acc_rdata != period_q) || (chk_d && acc_rdata != duty_q))
      err_q <= 1'b1;
  end
  assign bus.err = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^acc_rdata;
  assign bus.err      = 1'b0;
`endif

  assign bus.cmd_ready = cmd_ready;
  assign bus.done      = done;

endmodule

// File: tb/tb_pwm_servo_bus_master.sv
// Directed bench for pwm_servo_bus_master with a bus-access scoreboard and a
// small peripheral register model. Build with PWM_READBACK_VERIFY_EN to
// also cover the readback path.
module tb_pwm_servo_bus_master;

`ifdef PWM_READBACK_VERIFY_EN
  localparam int DONE_LAT = 13;
`else
  localparam int DONE_LAT = 9;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_servo_bus_master_if bus();

  pwm_servo_bus_master #(.BASE_ADDR(8'h00), .GAP_CYCLES(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
    bit          rd;
  } acc_t;

  acc_t        exp_acc[$];
  int          exp_done[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ndone = 0;
  bit          corrupt_d = 1'b0;
  logic [7:0]  corrupt_addr = 8'h00;
  logic [31:0] mem [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Peripheral model: samples the bus on the negedge of the access cycle.
  always @(negedge clk) begin
    if (bus.cs && bus.wr) mem[bus.addr[7:2]] = bus.d_out;
    if (bus.cs && bus.rd)
      bus.d_in = mem[bus.addr[7:2]] ^ ((corrupt_d && bus.addr == corrupt_addr) ? 32'h1 : 32'h0);
  end

  // Scoreboard monitor: every cs cycle must match the next expected access.
  always @(negedge clk) begin
    if (bus.cs) begin
      if (exp_acc.size() == 0) chk("unexpected_cs", bus.cs, 1'b0);
      else begin
        acc_t e;
        e = exp_acc.pop_front();
        chk("acc_cyc", cyc, e.cyc);
        chk("acc_addr", bus.addr, e.addr);
        chk("acc_data", bus.d_out, e.data);
        chk("acc_wr", bus.wr, !e.rd);
        chk("acc_rd", bus.rd, e.rd);
      end
    end else if (bus.wr || bus.rd) begin
      chk("strobe_without_cs", {bus.wr, bus.rd}, 0);
    end
    if (bus.done) begin
      ndone++;
      if (exp_done.size() == 0) chk("unexpected_done", bus.done, 1'b0);
      else chk("done_cyc", cyc, exp_done.pop_front());
    end
  end

  task automatic send(input logic [2:0] ch, input bit en, input logic [31:0] t,
                      input logic [31:0] d, input bit keep, output int k);
    int base;
    logic [31:0] dl;
    bit el, got;
    @(posedge clk); #1;
    bus.cmd_ch = ch; bus.cmd_en = en; bus.cmd_period = t; bus.cmd_duty = d;
    bus.cmd_valid = 1'b1;
    got = 0; k = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin got = 1; k = cyc; end
    end
    chk("accept_seen", got, 1);
    if (got) begin
      base = ch * 12;
      dl = (d > t) ? t : d;
      el = en && (t != 0);
      exp_acc.push_back('{cyc: k + 1, addr: 8'(base),     data: 32'd0,        rd: 1'b0});
      exp_acc.push_back('{cyc: k + 3, addr: 8'(base + 4), data: t,            rd: 1'b0});
      exp_acc.push_back('{cyc: k + 5, addr: 8'(base + 8), data: dl,           rd: 1'b0});
      exp_acc.push_back('{cyc: k + 7, addr: 8'(base),     data: {31'b0, el},  rd: 1'b0});
`ifdef PWM_READBACK_VERIFY_EN
      exp_acc.push_back('{cyc: k + 9,  addr: 8'(base + 4), data: 32'd0, rd: 1'b1});
      exp_acc.push_back('{cyc: k + 11, addr: 8'(base + 8), data: 32'd0, rd: 1'b1});
`endif
      exp_done.push_back(k + DONE_LAT);
    end
    @(posedge clk); #1;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_acc.size() != 0 || exp_done.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_acc.size() + exp_done.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k1, k2, n0;
    bus.cmd_valid = 1'b0; bus.cmd_ch = 3'd0; bus.cmd_en = 1'b0;
    bus.cmd_period = 32'h0; bus.cmd_duty = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cs", bus.cs, 0);
    chk("rst_wr", bus.wr, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_dout", bus.d_out, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: basic sequence on channel 2
    send(3'd2, 1'b1, 32'd1000, 32'd75, 1'b0, k1);
    drain();
    chk("t1_err", bus.err, 0);
    chk("t1_mem_T", mem[8'h1C >> 2], 32'd1000);

    // 2: channel 7, duty clamped to period
    send(3'd7, 1'b1, 32'd50, 32'd80, 1'b0, k1);
    drain();
    chk("t2_mem_D", mem[8'h5C >> 2], 32'd50);

    // 3: zero period forces the final enable to 0
    send(3'd4, 1'b1, 32'd0, 32'd10, 1'b0, k1);
    drain();
    chk("t3_mem_E", mem[8'h30 >> 2], 32'd0);

    // 4: cmd_valid held through the busy window
    send(3'd1, 1'b1, 32'd200, 32'd20, 1'b1, k1);
    send(3'd3, 1'b0, 32'd300, 32'd30, 1'b0, k2);
    chk("t4_second_accept", k2 - k1, DONE_LAT);
    drain();

    // 5: reset mid-sequence
    send(3'd5, 1'b1, 32'd400, 32'd40, 1'b0, k1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cs", bus.cs, 0);
    chk("t5_wr", bus.wr, 0);
    chk("t5_addr", bus.addr, 0);
    chk("t5_ready", bus.cmd_ready, 1);
    exp_acc.delete();
    exp_done.delete();
    n0 = ndone;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t5_no_done", ndone, n0);
    send(3'd5, 1'b1, 32'd500, 32'd60, 1'b0, k1);
    drain();

`ifdef PWM_READBACK_VERIFY_EN
    // 6: readback verify, good then corrupt D, then cleared by next accept
    send(3'd6, 1'b1, 32'd900, 32'd90, 1'b0, k1);
    drain();
    chk("t6_err_good", bus.err, 0);
    corrupt_d = 1'b1;
    corrupt_addr = 8'(6 * 12 + 8);
    send(3'd6, 1'b1, 32'd900, 32'd90, 1'b0, k1);
    drain();
    chk("t6_err_set", bus.err, 1);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", bus.err, 1);
    corrupt_d = 1'b0;
    send(3'd0, 1'b1, 32'd100, 32'd10, 1'b0, k1);
    chk("t6_err_cleared", bus.err, 0);
    drain();
    chk("t6_err_final", bus.err, 0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
